// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: default widths, FSM encodings
// and the active-low strobe levels of the SRAM-style CPU port.
package dmem_pkg;

    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 16;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic MEM_EN = 1'b0;
    localparam logic MEM_WR = 1'b0;
    localparam logic MEM_RD = 1'b1;

endpackage

// File: rtl/dmem_array.sv
// Word storage with one clocked write port and one combinational read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: clear sweep after reset, combinational CPU reads,
// clocked CPU writes, a preload port and saturating access counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CEN,
    input  logic              WEN,
    input  logic              OEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] Q,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              init_done,
    output logic              init_err,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] clr_addr_nxt;

    logic              clearing;
    logic              cpu_sel;
    logic              cpu_rd;
    logic              cpu_wr;
    logic              ld_fire;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    assign clearing = (state == ST_CLEAR);
    assign cpu_sel  = (CEN == MEM_EN);
    assign cpu_rd   = !clearing && cpu_sel && (WEN == MEM_RD);
    assign cpu_wr   = !clearing && cpu_sel && (WEN == MEM_WR);
    assign ld_ready = !clearing && !cpu_wr;
    assign ld_fire  = ld_valid && ld_ready;

    assign init_done = (state == ST_READY);
    assign Q         = (cpu_rd && (OEN == MEM_EN)) ? mem_rdata : '0;

    // State and sweep-address registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    // Sweep advances one word per cycle and holds on the last word
    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        case (state)
            ST_CLEAR: begin
                if (clr_addr == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = ST_READY;
                end else begin
                    clr_addr_nxt = clr_addr + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = ST_READY;
            end
        endcase
    end

    // Write source priority: clear sweep, then CPU, then preload
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (clearing) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
        end else if (cpu_wr) begin
            mem_we    = 1'b1;
            mem_waddr = A;
            mem_wdata = D;
        end else if (ld_fire) begin
            mem_we    = 1'b1;
            mem_waddr = ld_addr;
            mem_wdata = ld_data;
        end
    end

    // Sticky error flag and saturating access counters
    always_ff @(posedge clk) begin
        if (reset) begin
            init_err <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (clearing && cpu_sel) begin
                init_err <= 1'b1;
            end
            if (cpu_rd && (rd_count != '1)) begin
                rd_count <= rd_count + CNT_W'(1);
            end
            if (cpu_wr && (wr_count != '1)) begin
                wr_count <= wr_count + CNT_W'(1);
            end
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (A),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: clear sweep timing, CPU read/write, output
// gating, preload contention, access during clear, mid-sweep reset, saturation.
module tb_dmem_responder;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          CEN, WEN, OEN;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    logic [DW-1:0] q;
    logic          ld_ready, init_done, init_err;
    logic [15:0]   rd_count, wr_count;

    logic [DW-1:0] s_q;
    logic          s_ld_ready, s_init_done, s_init_err;
    logic [3:0]    s_rd_count, s_wr_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_rd   = 0;
    int exp_wr   = 0;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk(clk), .reset(reset), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D), .Q(q),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .init_done(init_done), .init_err(init_err), .rd_count(rd_count), .wr_count(wr_count)
    );

    dmem_responder #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D), .Q(s_q),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(s_ld_ready),
        .init_done(s_init_done), .init_err(s_init_err), .rd_count(s_rd_count), .wr_count(s_wr_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic cen, input logic wen, input logic oen,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        CEN = cen; WEN = wen; OEN = oen; A = a; D = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        CEN = 1'b1;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts edges until init_done; optionally watches Q/ld_ready stay low
    task automatic wait_init(input string tag, input int already, input int exp_cyc, input bit watch);
        int n;
        bit bad;
        n = already;
        bad = 1'b0;
        while (!init_done && n < 400) begin
            if (watch && (q !== '0 || ld_ready !== 1'b0)) bad = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
        if (watch) check_eq({tag, "_quiet"}, 32'(bad), 32'd0);
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_rd"}, 32'(rd_count), 32'(exp_rd));
        check_eq({tag, "_wr"}, 32'(wr_count), 32'(exp_wr));
    endtask

    initial begin
        reset = 1'b1; CEN = 1'b1; WEN = 1'b1; OEN = 1'b1; A = '0; D = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_init_done", 32'(init_done), 32'd0);
        check_eq("rst_ld_ready", 32'(ld_ready), 32'd0);
        check_eq("rst_q", q, 32'd0);
        check_eq("rst_init_err", 32'(init_err), 32'd0);
        check_counts("rst");
        @(negedge clk);
        reset = 1'b0;
        #1;
        wait_init("sweep1", 0, 128, 1'b1);

        // Read of a cleared word
        drive(1'b0, 1'b1, 1'b0, 7'h05, '0);
        check_eq("rd_cleared", q, 32'd0);
        tick(); exp_rd++;

        // Write then read back
        drive(1'b0, 1'b0, 1'b0, 7'h10, 32'hDEADBEEF);
        check_eq("wr_cycle_q", q, 32'd0);
        check_eq("wr_cycle_ld_ready", 32'(ld_ready), 32'd0);
        tick(); exp_wr++;
        drive(1'b0, 1'b1, 1'b0, 7'h10, '0);
        check_eq("rd_after_wr", q, 32'hDEADBEEF);
        tick(); exp_rd++;
        check_counts("wr_rd");

        // Output gating
        drive(1'b0, 1'b1, 1'b1, 7'h10, '0);
        check_eq("oen_high_q", q, 32'd0);
        tick(); exp_rd++;
        drive(1'b1, 1'b1, 1'b0, 7'h10, '0);
        check_eq("cen_high_q", q, 32'd0);
        tick();
        check_counts("gating");

        // Preload blocked by a CPU write, accepted the next cycle
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 7'h20; ld_data = 32'h12345678;
        CEN = 1'b0; WEN = 1'b0; OEN = 1'b1; A = 7'h21; D = 32'hCAFEF00D;
        #1;
        check_eq("ld_blocked", 32'(ld_ready), 32'd0);
        tick(); exp_wr++;
        drive(1'b1, 1'b1, 1'b1, 7'h00, '0);
        check_eq("ld_accept", 32'(ld_ready), 32'd1);
        tick();
        @(negedge clk);
        ld_valid = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 7'h20, '0);
        check_eq("rd_preload", q, 32'h12345678);
        tick(); exp_rd++;
        drive(1'b0, 1'b1, 1'b0, 7'h21, '0);
        check_eq("rd_cpu_wr", q, 32'hCAFEF00D);
        tick(); exp_rd++;
        check_counts("preload");

        // Read and preload of the same word in one cycle
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 7'h22; ld_data = 32'hA5A5A5A5;
        CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; A = 7'h22;
        #1;
        check_eq("rd_ld_same_old", q, 32'd0);
        check_eq("rd_ld_same_ready", 32'(ld_ready), 32'd1);
        tick(); exp_rd++;
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        check_eq("rd_ld_same_new", q, 32'hA5A5A5A5);
        tick(); exp_rd++;
        check_counts("rd_ld");

        // Seed 0x03 so the clear sweep has something to erase
        drive(1'b0, 1'b0, 1'b1, 7'h03, 32'h11111111);
        tick();

        // CPU write during the clear sweep is ignored and flagged
        do_reset(1);
        exp_rd = 0; exp_wr = 0;
        repeat (10) @(posedge clk);
        drive(1'b0, 1'b0, 1'b0, 7'h03, 32'hFFFFFFFF);
        check_eq("clr_acc_q", q, 32'd0);
        check_eq("clr_acc_ld_ready", 32'(ld_ready), 32'd0);
        tick();
        check_eq("clr_acc_err", 32'(init_err), 32'd1);
        check_counts("clr_acc");
        drive(1'b1, 1'b1, 1'b1, 7'h00, '0);
        wait_init("sweep2", 11, 128, 1'b0);
        check_eq("clr_acc_err_sticky", 32'(init_err), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 7'h03, '0);
        check_eq("rd_after_clr_acc", q, 32'd0);
        tick();

        // Reset in the middle of a sweep restarts it
        do_reset(1);
        repeat (60) @(posedge clk);
        do_reset(1);
        #1;
        exp_rd = 0; exp_wr = 0;
        wait_init("sweep3", 0, 128, 1'b1);
        check_eq("mid_rst_err", 32'(init_err), 32'd0);
        check_counts("mid_rst");
        drive(1'b0, 1'b1, 1'b0, 7'h10, '0);
        check_eq("rd_10_cleared", q, 32'd0);
        tick(); exp_rd++;

        // 20 writes: 16-bit counter tracks, 4-bit counter saturates
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b1, AW'(i), 32'(i));
            tick(); exp_wr++;
        end
        drive(1'b1, 1'b1, 1'b1, 7'h00, '0);
        check_counts("sat_main");
        check_eq("sat_wr_4b", 32'(s_wr_count), 32'h0000000F);
        check_eq("sat_rd_4b", 32'(s_rd_count), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 7'h13, '0);
        check_eq("rd_last_sat_wr", q, 32'd19);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
